dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: in-order request FIFO, one request in service,
// fixed LATENCY from acceptance to a registered completion pulse.
// Ports: clk, rst (sync, active-high); proc2mem_command/addr/data in;
// mem2proc_accept (comb), mem2proc_valid/data/error (registered), busy.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int QDEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  proc2mem_command,
  input  logic [31:0] proc2mem_addr,
  input  logic [31:0] proc2mem_data,
  output logic        mem2proc_accept,
  output logic        mem2proc_valid,
  output logic [31:0] mem2proc_data,
  output logic        mem2proc_error,
  output logic        mem2proc_busy
);

  localparam int PW = $clog2(QDEPTH);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);
  localparam logic [PW:0] CNT_FULL = (PW + 1)'(QDEPTH);

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic          st;
    logic          fault;
    logic [AW-1:0] idx;
    logic [31:0]   data;
  } req_t;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  req_t          slot_q, slot_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          valid_q, valid_d;
  logic [31:0]   data_q, data_d;
  logic          error_q, error_d;

  req_t          fifo_q [QDEPTH];
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic  cmd_ok, full, fifo_empty, take;
  logic  done, pop, bypass, push, mem_we;
  req_t  new_req;

  assign cmd_ok = (proc2mem_command == 2'd1)
               || (proc2mem_command == 2'd2);
  assign full       = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);

  assign mem2proc_accept = cmd_ok && !full;
  assign take = mem2proc_accept && !rst;

  // Fault is decided once at acceptance and travels with the request.
  always_comb begin
    new_req.st    = (proc2mem_command == 2'd2);
    new_req.fault = (proc2mem_addr[1:0] != 2'b00)
                 || ({2'b00, proc2mem_addr[31:2]} >= 32'(DEPTH_WORDS));
    new_req.idx   = proc2mem_addr[AW+1:2];
    new_req.data  = proc2mem_data;
  end

  assign done   = (state_q == BUSY) && (cnt_q == 3'd0);
  assign pop    = done && !fifo_empty;
  // Direct load into the slot only when nothing is queued ahead.
  assign bypass = take && fifo_empty && ((state_q == IDLE) || done);
  assign push   = take && !bypass;
  assign mem_we = done && slot_q.st && !slot_q.fault;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    error_d  = 1'b0;

    if (done) begin
      valid_d = 1'b1;
      error_d = slot_q.fault;
      data_d  = (slot_q.st || slot_q.fault) ? 32'd0 : mem_q[slot_q.idx];
    end

    if (pop) begin
      slot_d   = fifo_q[rd_ptr_q];
      cnt_d    = CNT_INIT;
      state_d  = BUSY;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else if (bypass) begin
      slot_d  = new_req;
      cnt_d   = CNT_INIT;
      state_d = BUSY;
    end else if (done) begin
      state_d = IDLE;
    end else if ((state_q == BUSY) && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      slot_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= 32'd0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      error_q  <= error_d;
    end
  end

  // Storage is not reset; writes are suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_q[wr_ptr_q] <= new_req;
    end
    if (!rst && mem_we) begin
      mem_q[slot_q.idx] <= slot_q.data;
    end
  end

  assign mem2proc_valid = valid_q;
  assign mem2proc_data  = data_q;
  assign mem2proc_error = error_q;
  assign mem2proc_busy  = (state_q == BUSY) || !fifo_empty;

endmodule
